// File: rtl/uart_byte_tx_if.sv
// Byte-wide handshake and status bundle between a byte sender and the UART transmitter.
// Latency: none, wires only.
// Backpressure: the sender should load only while tx_empty is high; a load while it is low is dropped.
//
// Signals:
//   tx_data    : byte to transmit, sampled on an accepted load
//   ld_tx_data : single-cycle load strobe
//   tx_enable  : permits new frames to start
//   tx_empty   : holding register empty, a load is accepted this cycle
//   tx_out     : serial line, 8N1, idle high
//   tx_busy    : a frame is on the line
//   tx_overrun : sticky, a load was dropped since reset
interface uart_byte_tx_if;
    logic [7:0] tx_data;
    logic       ld_tx_data;
    logic       tx_enable;
    logic       tx_empty;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_overrun;

    // Byte sender side.
    modport master (
        output tx_data,
        output ld_tx_data,
        output tx_enable,
        input  tx_empty,
        input  tx_out,
        input  tx_busy,
        input  tx_overrun
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  ld_tx_data,
        input  tx_enable,
        output tx_empty,
        output tx_out,
        output tx_busy,
        output tx_overrun
    );
endinterface

// File: rtl/uart_byte_tx.sv
// Double-buffered 8N1 UART byte transmitter (holding register + shift register).
// Latency: a load accepted at edge k in IDLE with tx_enable high drives the start bit from edge k+1.
// Backpressure: tx_empty low means the holding register is full; loads then are dropped and flag tx_overrun.
//
// Ports:
//   clk : sole clock, all state updates on the rising edge
//   rst : synchronous active-high reset; truncates any frame and empties both buffers
//   bus : uart_byte_tx_if.slave (tx_data, ld_tx_data, tx_enable in; tx_empty, tx_out, tx_busy, tx_overrun out)
// CLKS_PER_BIT sets clock cycles per serial bit; legal values are >= 2.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_tx_if.slave  bus
);

    localparam int              BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_out_q;
    logic              tx_out_d;

    logic [7:0]        hold_q;
    logic              hold_full_q;
    logic              overrun_q;

    logic              baud_done;
    logic              frame_ready;
    logic              transfer;
    logic              load_ok;
    logic              load_drop;

    // Last cycle of the current serial bit.
    assign baud_done   = (baud_q == BAUD_LAST);

    // A buffered byte may start a frame only while enabled; a frame already
    // on the line is never aborted by tx_enable going low.
    assign frame_ready = hold_full_q && bus.tx_enable;

    // Loads need an empty holding register and transfers need a full one, so
    // the two can never coincide and need no arbitration.
    assign load_ok     = bus.ld_tx_data && !hold_full_q;
    assign load_drop   = bus.ld_tx_data &&  hold_full_q;

    //--------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------
    // FSM next-state logic; also flags the holding->shift transfer
    //--------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        transfer = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_ready) begin
                    state_d  = S_START;
                    transfer = 1'b1;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done && (bit_q == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when a byte waits,
                    // so back-to-back frames have no idle gap.
                    if (frame_ready) begin
                        state_d  = S_START;
                        transfer = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // FSM output / datapath next-value logic
    //--------------------------------------------------------------------
    always_comb begin
        baud_d   = baud_done ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_out_d = tx_out_q;

        case (state_q)
            S_IDLE: begin
                baud_d   = '0;
                tx_out_d = 1'b1;
                if (transfer) begin
                    shift_d  = hold_q;
                    tx_out_d = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    // LSB first: present bit 0 and shift the rest down.
                    tx_out_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    if (bit_q == 3'd7) begin
                        tx_out_d = 1'b1;
                    end else begin
                        tx_out_d = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        bit_d    = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    if (transfer) begin
                        shift_d  = hold_q;
                        tx_out_d = 1'b0;
                    end else begin
                        tx_out_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_out_d = 1'b1;
            end
        endcase

        // Both counters restart from zero on every state entry.
        if (state_d != state_q) begin
            baud_d = '0;
            bit_d  = '0;
        end
    end

    //--------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
        end
    end

    // Holding register and overrun flag. Reset wins over a load in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (transfer) begin
                hold_full_q <= 1'b0;
            end else if (load_ok) begin
                hold_q      <= bus.tx_data;
                hold_full_q <= 1'b1;
            end
            if (load_drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------
    assign bus.tx_out     = tx_out_q;
    assign bus.tx_empty   = ~hold_full_q;
    assign bus.tx_busy    = (state_q != S_IDLE);
    assign bus.tx_overrun = overrun_q;

endmodule
